// File: rtl/winner_search_if.sv
// Bundle between the SOM winner search and its neighbours: distance stream in,
// winner coordinates and the column sweep out.
interface winner_search_if #(
   parameter int DW = 16
);
   logic          start;
   logic          dist_valid;
   logic [DW-1:0] dist_in;
   logic          col_ready;
   logic          busy;
   logic [2:0]    X_c;
   logic [2:0]    Y_c;
   logic [DW-1:0] min_dist;
   logic          win_valid;
   logic [2:0]    X_in;
   logic          col_valid;
   logic          sweep_done;

   // Handshake: a dist_in sample is consumed on every edge where dist_valid=1
   // while searching (no back-pressure). A column beat transfers on every edge
   // where col_valid & col_ready; X_in/col_valid hold until that happens.
   modport master (
      output start, dist_valid, dist_in, col_ready,
      input  busy, X_c, Y_c, min_dist, win_valid, X_in, col_valid, sweep_done
   );

   modport slave (
      input  start, dist_valid, dist_in, col_ready,
      output busy, X_c, Y_c, min_dist, win_valid, X_in, col_valid, sweep_done
   );
endinterface

// File: rtl/winner_search.sv
// Best-matching-unit search over 64 streamed distances of an 8x8 SOM, followed
// by a handshaked sweep of column indices 0..7 for the downstream stages.
module winner_search #(
   parameter int DW = 16
) (
   input  logic              clk,
   input  logic              rst,
   winner_search_if.slave    bus,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_SWEEP  = 2'd2
   } state_t;

   state_t        r_state;
   logic [5:0]    r_cnt;
   logic [DW-1:0] r_best;
   logic [2:0]    r_best_x;
   logic [2:0]    r_best_y;
   logic          r_busy;
   logic [2:0]    r_x_c;
   logic [2:0]    r_y_c;
   logic [DW-1:0] r_min_dist;
   logic          r_win_valid;
   logic [2:0]    r_x_in;
   logic          r_col_valid;
   logic          r_sweep_done;

   logic          w_take;
   logic [DW-1:0] w_best_d;
   logic [2:0]    w_best_x;
   logic [2:0]    w_best_y;

   // Strict compare so ties keep the earliest neuron; sample 0 always seeds.
   always_comb begin
      w_take   = (r_cnt == 6'd0) || (bus.dist_in < r_best);
      w_best_d = r_best;
      w_best_x = r_best_x;
      w_best_y = r_best_y;
      if (w_take) begin
         w_best_d = bus.dist_in;
         w_best_x = r_cnt[5:3];
         w_best_y = r_cnt[2:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 6'd0;
         r_best       <= '0;
         r_best_x     <= 3'd0;
         r_best_y     <= 3'd0;
         r_busy       <= 1'b0;
         r_x_c        <= 3'd0;
         r_y_c        <= 3'd0;
         r_min_dist   <= '0;
         r_win_valid  <= 1'b0;
         r_x_in       <= 3'd0;
         r_col_valid  <= 1'b0;
         r_sweep_done <= 1'b0;
      end else begin
         r_win_valid  <= 1'b0;
         r_sweep_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_SEARCH;
                  r_cnt   <= 6'd0;
                  r_busy  <= 1'b1;
               end
            end
            S_SEARCH: begin
               if (bus.dist_valid) begin
                  r_cnt    <= r_cnt + 6'd1;
                  r_best   <= w_best_d;
                  r_best_x <= w_best_x;
                  r_best_y <= w_best_y;
                  // Publish from the next-best values so sample 63 is included.
                  if (r_cnt == 6'd63) begin
                     r_x_c       <= w_best_x;
                     r_y_c       <= w_best_y;
                     r_min_dist  <= w_best_d;
                     r_win_valid <= 1'b1;
                     r_state     <= S_SWEEP;
                     r_x_in      <= 3'd0;
                     r_col_valid <= 1'b1;
                  end
               end
            end
            S_SWEEP: begin
               if (r_col_valid && bus.col_ready) begin
                  if (r_x_in == 3'd7) begin
                     r_state      <= S_IDLE;
                     r_col_valid  <= 1'b0;
                     r_x_in       <= 3'd0;
                     r_busy       <= 1'b0;
                     r_sweep_done <= 1'b1;
                  end else begin
                     r_x_in <= r_x_in + 3'd1;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_col_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.X_c        = r_x_c;
   assign bus.Y_c        = r_y_c;
   assign bus.min_dist   = r_min_dist;
   assign bus.win_valid  = r_win_valid;
   assign bus.X_in       = r_x_in;
   assign bus.col_valid  = r_col_valid;
   assign bus.sweep_done = r_sweep_done;
   assign o_dbg_state    = r_state;

endmodule

// File: doc/winner_search.md
Name: winner_search

Overview:
- Upstream neighbour of the 8x8 SOM neighbourhood-select stage.
- Consumes a stream of 64 neuron distances, one per neuron, and tracks the minimum to find the best-matching unit (winner).
- Registers the winner coordinates X_c/Y_c.
- Then sweeps the column index X_in 0..7 under a valid/ready handshake. This lets the neighbourhood-select and weight-update stages process one column per accepted beat.

Parameters:
- DW, 16, width of each distance sample and of min_dist.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a new search; sampled only in IDLE.
- dist_valid  input  1  dist_in holds a valid sample this cycle.
- dist_in  input  DW  unsigned distance of the current neuron.
- col_ready  input  1  downstream accepts the current X_in beat.
- busy  output  1  high in SEARCH or SWEEP.
- X_c  output  3  winner column (x).
- Y_c  output  3  winner row (y).
- min_dist  output  DW  winner distance.
- win_valid  output  1  one-cycle pulse when X_c/Y_c/min_dist update.
- X_in  output  3  column currently offered downstream.
- col_valid  output  1  X_in is valid.
- sweep_done  output  1  one-cycle pulse after column 7 is accepted.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0: busy, X_c, Y_c, min_dist, win_valid, X_in, col_valid, sweep_done.
  - Internal sample counter and running best are cleared.
  - Reset asserted mid-SEARCH or mid-SWEEP aborts; the partial result is discarded.
- States: IDLE, SEARCH, SWEEP.
- IDLE:
  - busy=0, col_valid=0.
  - start=1 -> SEARCH next cycle, with sample count cnt=0.
  - dist_valid is ignored, including when it coincides with start.
- SEARCH:
  - busy=1.
  - Each cycle with dist_valid=1 consumes one sample; cycles with dist_valid=0 are stalls with no state change.
  - Sample index cnt (6 bits) maps to x=cnt[5:3], y=cnt[2:0]. Neuron order is column-major: column 0, rows 0..7 first.
  - Running best loads unconditionally when cnt==0. Otherwise it loads only if dist_in < best_dist (strict unsigned compare).
  - Ties therefore keep the lowest index.
  - An all-ones distance at cnt==0 must still load.
- SEARCH exit:
  - The sample with cnt==63 is compared like any other.
  - The same edge loads X_c/Y_c/min_dist from the final best, including sample 63.
  - Next cycle: win_valid=1 for exactly one cycle, state=SWEEP, X_in=0, col_valid=1.
- Output holding: X_c, Y_c and min_dist hold stable from win_valid until the next completed search. They do not change during the next SEARCH. Downstream decodes X_c/Y_c combinationally against X_in.
- SWEEP:
  - busy=1, col_valid=1.
  - X_in advances by 1 on each cycle with col_valid & col_ready.
  - X_in and col_valid are held while col_ready=0.
  - When X_in==7 is accepted: next cycle state=IDLE, col_valid=0, X_in=0, sweep_done=1 for one cycle.
  - start is ignored while busy.
- Latency:
  - With dist_valid held high: win_valid arrives 65 cycles after the cycle start is sampled.
  - With col_ready held high: sweep takes 8 beats; sweep_done follows 8 cycles after win_valid.
- Width rules:
  - cnt wraps naturally from 63 to 0 but is reset on start.
  - X_in is 3 bits and never exceeds 7.

Test Plan:
- Reset then idle: hold rst 2 cycles with start=1 -> all outputs 0. Then start with dist_valid=0 for 10 cycles -> busy=1, win_valid=0.
- Basic winner: start, stream 64 samples with dist=100 except cnt=19 dist=5 -> win_valid pulses; X_c=2, Y_c=3, min_dist=5; X_in 0..7 on 8 consecutive cycles; sweep_done=1 on the cycle after X_in=7.
- Tie and boundary:
  - All samples =16'hFFFF -> X_c=0, Y_c=0, min_dist=16'hFFFF.
  - Rerun with cnt=63 as the unique minimum 0 -> X_c=7, Y_c=7, min_dist=0.
  - Rerun with equal minima at cnt 10 and 40 -> X_c=1, Y_c=2.
- Stalls: randomly deassert dist_valid and col_ready (about 30%) -> same winner as the no-stall run. X_in holds while col_ready=0; no column is skipped or repeated.
- Result holding and start masking: pulse start during SWEEP -> ignored. During the next SEARCH, X_c/Y_c retain the prior winner until the new win_valid.
- Mid-operation reset: assert rst after 30 samples -> next cycle IDLE with outputs 0. A fresh full search then yields the correct winner, unaffected by the aborted samples.
